// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared types and constants for the instruction memory loader
package imem_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int WORD_W = 32;
  localparam int BYTES_PER_WORD = 4;
  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

endpackage

// File: rtl/imem_byte_assembler.sv
// rtl/imem_byte_assembler.sv - packs accepted bytes into 32-bit words, pulses word_done after the 4th byte
module imem_byte_assembler
  import imem_loader_pkg::*;
#(
  parameter int BIG_ENDIAN = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              byte_en,
  input  logic [7:0]        byte_data,
  output logic [1:0]        byte_cnt,
  output logic [WORD_W-1:0] word,
  output logic              word_done
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_cnt  <= 2'd0;
      word      <= '0;
      word_done <= 1'b0;
    end else if (clear) begin
      byte_cnt  <= 2'd0;
      word      <= '0;
      word_done <= 1'b0;
    end else begin
      word_done <= byte_en && (byte_cnt == LAST_BYTE);
      if (byte_en) begin
        byte_cnt <= byte_cnt + 2'd1;
        // Shifting in from the low end leaves the first byte on top; from the high end, at the bottom.
        if (BIG_ENDIAN != 0) word <= {word[WORD_W-9:0], byte_data};
        else                 word <= {byte_data, word[WORD_W-1:8]};
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - streams bytes into instruction memory while holding the core in reset
// Optional trailer-word XOR checksum is built when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int IM_DEPTH   = 256,
  parameter int BIG_ENDIAN = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [8:0]  len,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        im_we,
  output logic [31:0] im_addr,
  output logic [31:0] im_wdata,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [8:0] DEPTH_CAP = 9'(IM_DEPTH);

  state_t            state, state_next;
  logic [8:0]        word_cnt, word_idx, idx_inc, len_cap;
  logic              byte_fire, word_last_byte, last_word, start_go, err_next;
  logic [1:0]        asm_cnt;
  logic [WORD_W-1:0] asm_word;
  logic              asm_done;

  assign byte_fire      = byte_valid & byte_ready;
  assign word_last_byte = byte_fire && (asm_cnt == LAST_BYTE);
  assign len_cap        = (len > DEPTH_CAP) ? DEPTH_CAP : len;
  assign idx_inc        = word_idx + 9'd1;
  assign last_word      = (idx_inc == word_cnt);
  assign im_wdata       = asm_word;

  imem_byte_assembler #(.BIG_ENDIAN(BIG_ENDIAN)) u_asm (
    .clk       (clk),
    .reset     (reset),
    .clear     (start_go),
    .byte_en   (byte_fire),
    .byte_data (byte_data),
    .byte_cnt  (asm_cnt),
    .word      (asm_word),
    .word_done (asm_done)
  );

  always_comb begin
    state_next = state;
    start_go   = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          start_go   = 1'b1;
          state_next = (len_cap == 9'd0) ? ST_DONE : ST_LOAD;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_LOAD:  if (asm_done && last_word) state_next = ST_CHECK;
      ST_CHECK: if (asm_done) state_next = ST_DONE;
`else
      ST_LOAD:  if (asm_done && last_word) state_next = ST_DONE;
`endif
      default: state_next = state;
    endcase
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [WORD_W-1:0] wsum_xor;

  always_comb begin
    err_next = err;
    if (start_go) err_next = 1'b0;
    else if ((state == ST_CHECK) && asm_done) err_next = (asm_word != wsum_xor);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wsum_xor <= '0;
      err      <= 1'b0;
    end else begin
      err <= err_next;
      if (start_go)   wsum_xor <= '0;
      else if (im_we) wsum_xor <= wsum_xor ^ asm_word;
    end
  end
`else
  assign err_next = 1'b0;
  assign err      = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      word_cnt   <= 9'd0;
      word_idx   <= 9'd0;
      im_addr    <= 32'd0;
      im_we      <= 1'b0;
      byte_ready <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cpu_hold   <= 1'b1;
    end else begin
      state      <= state_next;
      im_we      <= (state == ST_LOAD) && word_last_byte;
      // The cycle after a word's last byte is the write (or compare) cycle, so no byte is taken then.
      byte_ready <= ((state_next == ST_LOAD) || (state_next == ST_CHECK)) && !word_last_byte;
      busy       <= (state_next == ST_LOAD) || (state_next == ST_CHECK);
      done       <= (state_next == ST_DONE);
      cpu_hold   <= (state_next != ST_DONE) || err_next;
      if (start_go) begin
        word_cnt <= len_cap;
        word_idx <= 9'd0;
        im_addr  <= 32'd0;
      end else if (im_we) begin
        word_idx <= idx_inc;
        // Address stays on the final word so it never points past the memory.
        if (!last_word) im_addr <= {21'd0, idx_inc, 2'b00};
      end
    end
  end

endmodule
